ping_pong_counter: RTL

Tick-driven bidirectional counter that sits directly downstream of the clock divider. It consumes one of the divider's one-cycle-per-period outputs (clk1_2/3/4/8 or dclk) as a step enable, rather than as a clock. It bounces its output between programmable bounds `min` and `max` and reports direction and bounce events. The whole block runs on the single system clock `clk`; divided signals are never used as clocks.

---
 rtl/ping_pong_counter.sv | 93 +++++++++
 1 files changed

// File: rtl/ping_pong_counter.sv
// Bidirectional counter bouncing between min and max, advanced by divider ticks used as step enables on clk.
// Define PING_PONG_TICK_EDGE_EN to step once per rising edge of tick instead of once per high cycle.
module ping_pong_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tick,
  input  logic             flip,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] out,
  output logic             direction,
  output logic             wrap
);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  logic [WIDTH-1:0] out_q, out_d;
  dir_e             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             tick_ok;
  logic             step;
  logic             eff_up;

`ifdef PING_PONG_TICK_EDGE_EN
  // Tracks tick even while disabled so re-enabling never sees a stale edge.
  logic tick_q;

  always_ff @(posedge clk) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick;
  end

  assign tick_ok = tick & ~tick_q;
`else
  assign tick_ok = tick;
`endif

  assign step   = enable & tick_ok & (max > min);
  assign eff_up = (dir_q == DIR_UP) ^ flip;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (step) begin
      if ((out_q > max) || (out_q < min)) begin
        out_d = min;
        dir_d = DIR_UP;
      end else if (eff_up) begin
        if (out_q == max) begin
          out_d  = max - 1'b1;
          dir_d  = DIR_DOWN;
          wrap_d = 1'b1;
        end else begin
          out_d = out_q + 1'b1;
          dir_d = DIR_UP;
        end
      end else begin
        if (out_q == min) begin
          out_d  = min + 1'b1;
          dir_d  = DIR_UP;
          wrap_d = 1'b1;
        end else begin
          out_d = out_q - 1'b1;
          dir_d = DIR_DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      dir_q  <= DIR_UP;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  assign out       = out_q;
  assign direction = (dir_q == DIR_UP);
  assign wrap      = wrap_q;

endmodule
